fake_axi4_slave_mem: RTL and testbench
======================================

Name: fake_axi4_slave_mem

Overview:
Synthesizable AXI4 slave memory model. It terminates the fake AXI4 master's write and read channels in block-level benches and FPGA bring-up. It stores full-width data words in an internal array and services one write burst and one read burst at a time, each channel independent. It supports FIXED and INCR bursts and flags protocol misuse through the response codes.

Parameters:
C_S00_AXI_ADDR_WIDTH, 32, byte address width
C_S00_AXI_DATA_WIDTH, 256, data width in bits; power of 2, at least 32
C_MEM_DEPTH_LOG2, 8, log2 of memory depth in data words

Ports:
s_axi4_aclk  in  1  clock
s_axi4_areset  in  1  reset, asynchronous, active-high
s_axi4_awid/awaddr/awlen/awburst  in  4/ADDR/8/2  write address; awsize, awlock, awcache, awprot, awqos, awregion accepted and ignored
s_axi4_awvalid  in  1;  s_axi4_awready  out  1
s_axi4_wdata/wstrb/wlast/wvalid  in  DATA/DATA/8/1/1  write data
s_axi4_wready  out  1
s_axi4_bid/bresp/bvalid  out  4/2/1;  s_axi4_bready  in  1
s_axi4_arid/araddr/arlen/arburst  in  4/ADDR/8/2  read address; other AR sideband accepted and ignored
s_axi4_arvalid  in  1;  s_axi4_arready  out  1
s_axi4_rid/rdata/rresp/rlast/rvalid  out  4/DATA/2/1/1;  s_axi4_rready  in  1

Behaviour:
- Reset is asynchronous and active-high.
  - On reset, all outputs are 0, and both state machines go to IDLE.
  - Memory contents are not reset. The array initialises to all zeros at configuration time.
  - If reset asserts mid-burst, the burst is abandoned and no response is issued.
- Address decoding:
  - LSB = log2(DATA/8).
  - Word index = addr[LSB +: C_MEM_DEPTH_LOG2].
  - Upper address bits and sub-word offset bits are ignored.
  - For INCR bursts, the index increments by 1 per beat and wraps modulo 2^C_MEM_DEPTH_LOG2.
  - awsize/arsize are ignored; every beat is treated as full width.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1, wready=0. On awvalid&awready, latch id, index, len and burst, clear the beat counter and err flag, and go to W_DATA.
  - W_DATA: awready=0, wready=1.
    - Each wvalid&wready beat writes the bytes whose wstrb bit is set; other bytes keep their value.
    - The err flag is set if wlast differs from (beat==len) on any beat.
    - If burst==WRAP (2'b10) or reserved (2'b11), memory writes are suppressed and err is set.
    - On the beat with beat==len, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp=err?2'b10:2'b00. Hold until bready, then go to W_IDLE. Back-to-back AW is not accepted until that cycle.
  - A beat presented before AW is accepted is not consumed (wready=0).
- Read FSM, states R_IDLE, R_FETCH, R_DATA:
  - R_IDLE: arready=1. On handshake, latch id, index, len, burst and err=(burst[1]==1), then go to R_FETCH.
  - R_FETCH: for one cycle, register rdata<=mem[index], rlast<=(len==0), then go to R_DATA. The first rvalid therefore appears 2 cycles after the AR handshake edge.
  - R_DATA: rvalid=1, rid=latched id, rresp=err?2'b10:2'b00.
    - On rvalid&rready with rlast=1: clear rvalid and go to R_IDLE.
    - Otherwise, on the same edge, advance the index (INCR only), load the next rdata, and set rlast for the final beat. This gives full throughput of one beat per cycle under continuous rready.
  - For an erroring burst, rdata=0 and len+1 beats are still returned.
  - rdata, rlast and rresp hold stable while rvalid=1 and rready=0.
- Read/write collision: if a read fetch and a write land on the same word on the same edge, the read returns the old data. The write is visible from the next fetch onward.
- Both channels operate concurrently; neither blocks the other.

Test Plan:
1. Single write, then read:
   - Stimulus: AW addr=0x40 len=0 INCR, wdata=0xA5..A5, all strb set, wlast=1; then AR addr=0x40 len=0.
   - Required: bresp=00 bid echoes; rdata=0xA5..A5, rlast=1, rresp=00, rvalid 2 cycles after the AR handshake.
2. INCR burst with partial strobe:
   - Stimulus: write len=3 at addr 0x0 with beat data k+1, beat 2 strb=0x0000000F; then read len=3.
   - Required: beats 1,2,4 return 1,2,4; beat 3 returns its low 4 bytes = 3, with the remaining bytes equal to prior contents (0).
3. Wrap-around and backpressure:
   - Stimulus: INCR len=1 write at word index 255 with data X,Y; read back with rready toggling 1-0-1.
   - Required: X is stored at index 255 and Y at index 0; rdata is stable during the stall; exactly 2 beats are returned.
4. Protocol error:
   - Stimulus: write len=2 with wlast asserted on beat 1; separately, an AR with arburst=2'b10 len=1.
   - Required: exactly 3 beats are consumed and bresp=2'b10; the read returns 2 beats with rresp=2'b10 and rdata=0.
5. FIXED burst and concurrency:
   - Stimulus: FIXED len=3 write to index 5 with data 1..4, while concurrently reading index 9 len=7.
   - Required: index 5 holds 4 and index 6 is unchanged; the read completes 8 beats without stalling the write.
6. Reset mid-burst:
   - Stimulus: assert reset after beat 1 of a len=3 write, release it, then read the burst's first index.
   - Required: bvalid is never asserted and all outputs are 0 during reset; beat 0 data is retained; awready=1 one cycle after release.

Source files
------------

// File: rtl/fake_axi4_slave_mem.sv
// AXI4 slave memory model: full-width word array, one write and one read burst
// in flight at a time on independent channels. FIXED/INCR only; misuse -> SLVERR.
module fake_axi4_slave_mem #(
  parameter int C_S00_AXI_ADDR_WIDTH = 32,
  parameter int C_S00_AXI_DATA_WIDTH = 256,
  parameter int C_MEM_DEPTH_LOG2     = 8
) (
  input  logic                              s_axi4_aclk,
  input  logic                              s_axi4_areset,
  // write address
  input  logic [3:0]                        s_axi4_awid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s_axi4_awaddr,
  input  logic [7:0]                        s_axi4_awlen,
  input  logic [2:0]                        s_axi4_awsize,
  input  logic [1:0]                        s_axi4_awburst,
  input  logic                              s_axi4_awlock,
  input  logic [3:0]                        s_axi4_awcache,
  input  logic [2:0]                        s_axi4_awprot,
  input  logic [3:0]                        s_axi4_awqos,
  input  logic [3:0]                        s_axi4_awregion,
  input  logic                              s_axi4_awvalid,
  output logic                              s_axi4_awready,
  // write data
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
  input  logic                              s_axi4_wlast,
  input  logic                              s_axi4_wvalid,
  output logic                              s_axi4_wready,
  // write response
  output logic [3:0]                        s_axi4_bid,
  output logic [1:0]                        s_axi4_bresp,
  output logic                              s_axi4_bvalid,
  input  logic                              s_axi4_bready,
  // read address
  input  logic [3:0]                        s_axi4_arid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s_axi4_araddr,
  input  logic [7:0]                        s_axi4_arlen,
  input  logic [2:0]                        s_axi4_arsize,
  input  logic [1:0]                        s_axi4_arburst,
  input  logic                              s_axi4_arlock,
  input  logic [3:0]                        s_axi4_arcache,
  input  logic [2:0]                        s_axi4_arprot,
  input  logic [3:0]                        s_axi4_arqos,
  input  logic [3:0]                        s_axi4_arregion,
  input  logic                              s_axi4_arvalid,
  output logic                              s_axi4_arready,
  // read data
  output logic [3:0]                        s_axi4_rid,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s_axi4_rdata,
  output logic [1:0]                        s_axi4_rresp,
  output logic                              s_axi4_rlast,
  output logic                              s_axi4_rvalid,
  input  logic                              s_axi4_rready
);

  localparam int NB    = C_S00_AXI_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IW    = C_MEM_DEPTH_LOG2;
  localparam int DEPTH = 1 << IW;
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [1:0]    BURST_INCR = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  logic [C_S00_AXI_DATA_WIDTH-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------- write
  wstate_t                     r_wstate, w_wstate_nxt;
  logic                        r_awready, r_wready, r_bvalid;
  logic [3:0]                  r_wid;
  logic [IW-1:0]               r_widx;
  logic [7:0]                  r_wlen, r_wbeat;
  logic [1:0]                  r_wburst;
  logic                        r_werr;
  logic                        w_awfire, w_wfire, w_wlast_beat;

  assign w_awfire     = s_axi4_awvalid & r_awready;
  assign w_wfire      = s_axi4_wvalid & r_wready;
  assign w_wlast_beat = (r_wbeat == r_wlen);

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_awfire) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_wfire && w_wlast_beat) w_wstate_nxt = W_RESP;
      W_RESP:  if (r_bvalid && s_axi4_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they read 0 in reset
  // and awready only rises on the first edge after release.
  always_ff @(posedge s_axi4_aclk or posedge s_axi4_areset) begin
    if (s_axi4_areset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
    end
  end

  always_ff @(posedge s_axi4_aclk or posedge s_axi4_areset) begin
    if (s_axi4_areset) begin
      r_wid    <= '0;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wburst <= '0;
      r_wbeat  <= '0;
      r_werr   <= 1'b0;
    end else if (w_awfire) begin
      r_wid    <= s_axi4_awid;
      r_widx   <= s_axi4_awaddr[LSB +: IW];
      r_wlen   <= s_axi4_awlen;
      r_wburst <= s_axi4_awburst;
      r_wbeat  <= '0;
      r_werr   <= s_axi4_awburst[1];
    end else if (w_wfire) begin
      r_wbeat <= r_wbeat + 8'd1;
      if (s_axi4_wlast != w_wlast_beat) r_werr <= 1'b1;
      if (r_wburst == BURST_INCR) r_widx <= r_widx + IDX_ONE;
    end
  end

  // WRAP and reserved bursts still consume beats but never touch the array
  always_ff @(posedge s_axi4_aclk) begin
    if (w_wfire && !r_wburst[1]) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi4_wstrb[b]) r_mem[r_widx][b*8 +: 8] <= s_axi4_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi4_awready = r_awready;
  assign s_axi4_wready  = r_wready;
  assign s_axi4_bvalid  = r_bvalid;
  assign s_axi4_bid     = r_wid;
  assign s_axi4_bresp   = {r_bvalid & r_werr, 1'b0};

  // ---------------------------------------------------------------- read
  rstate_t                         r_rstate, w_rstate_nxt;
  logic                            r_arready, r_rvalid;
  logic [3:0]                      r_rid;
  logic [IW-1:0]                   r_ridx, w_ridx_nxt;
  logic [7:0]                      r_rlen, r_rbeat;
  logic [1:0]                      r_rburst;
  logic                            r_rerr, r_rlast;
  logic [C_S00_AXI_DATA_WIDTH-1:0] r_rdata;
  logic                            w_arfire, w_rfire;

  assign w_arfire   = s_axi4_arvalid & r_arready;
  assign w_rfire    = r_rvalid & s_axi4_rready;
  assign w_ridx_nxt = (r_rburst == BURST_INCR) ? r_ridx + IDX_ONE : r_ridx;

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_arfire) w_rstate_nxt = R_FETCH;
      R_FETCH: w_rstate_nxt = R_DATA;
      R_DATA:  if (w_rfire && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi4_aclk or posedge s_axi4_areset) begin
    if (s_axi4_areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
    end
  end

  // Array reads sample pre-edge contents, so a same-edge write is seen only by
  // the following fetch.
  always_ff @(posedge s_axi4_aclk or posedge s_axi4_areset) begin
    if (s_axi4_areset) begin
      r_rid    <= '0;
      r_ridx   <= '0;
      r_rlen   <= '0;
      r_rburst <= '0;
      r_rbeat  <= '0;
      r_rerr   <= 1'b0;
      r_rlast  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_arfire) begin
        r_rid    <= s_axi4_arid;
        r_ridx   <= s_axi4_araddr[LSB +: IW];
        r_rlen   <= s_axi4_arlen;
        r_rburst <= s_axi4_arburst;
        r_rbeat  <= '0;
        r_rerr   <= s_axi4_arburst[1];
      end
      if (r_rstate == R_FETCH) begin
        r_rdata <= r_rerr ? '0 : r_mem[r_ridx];
        r_rlast <= (r_rlen == 8'd0);
      end else if (r_rstate == R_DATA && w_rfire) begin
        if (r_rlast) begin
          r_rlast <= 1'b0;
        end else begin
          r_ridx  <= w_ridx_nxt;
          r_rdata <= r_rerr ? '0 : r_mem[w_ridx_nxt];
          r_rbeat <= r_rbeat + 8'd1;
          r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
        end
      end
    end
  end

  assign s_axi4_arready = r_arready;
  assign s_axi4_rvalid  = r_rvalid;
  assign s_axi4_rid     = r_rid;
  assign s_axi4_rdata   = r_rdata;
  assign s_axi4_rlast   = r_rlast;
  assign s_axi4_rresp   = {r_rvalid & r_rerr, 1'b0};

  // Sideband, sub-word and upper address bits carry no meaning for this model
  logic w_unused;
  assign w_unused = ^{s_axi4_awsize, s_axi4_awlock, s_axi4_awcache, s_axi4_awprot,
                      s_axi4_awqos, s_axi4_awregion, s_axi4_awaddr,
                      s_axi4_arsize, s_axi4_arlock, s_axi4_arcache, s_axi4_arprot,
                      s_axi4_arqos, s_axi4_arregion, s_axi4_araddr};

endmodule

// File: tb/tb_fake_axi4_slave_mem.sv
// Bench for fake_axi4_slave_mem: directed vector table, corner-case sequences
// and random bursts checked against a word-array reference model.
module tb_fake_axi4_slave_mem;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RESV = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   awid = '0;
  logic [31:0]  awaddr = '0;
  logic [7:0]   awlen = '0;
  logic [2:0]   awsize = '0;
  logic [1:0]   awburst = '0;
  logic         awlock = 1'b0;
  logic [3:0]   awcache = '0, awqos = '0, awregion = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0, awready;
  logic [255:0] wdata = '0;
  logic [31:0]  wstrb = '0;
  logic         wlast = 1'b0, wvalid = 1'b0, wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready = 1'b0;
  logic [3:0]   arid = '0;
  logic [31:0]  araddr = '0;
  logic [7:0]   arlen = '0;
  logic [2:0]   arsize = '0;
  logic [1:0]   arburst = '0;
  logic         arlock = 1'b0;
  logic [3:0]   arcache = '0, arqos = '0, arregion = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0, arready;
  logic [3:0]   rid;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready = 1'b0;

  fake_axi4_slave_mem dut (
    .s_axi4_aclk(clk), .s_axi4_areset(rst),
    .s_axi4_awid(awid), .s_axi4_awaddr(awaddr), .s_axi4_awlen(awlen),
    .s_axi4_awsize(awsize), .s_axi4_awburst(awburst), .s_axi4_awlock(awlock),
    .s_axi4_awcache(awcache), .s_axi4_awprot(awprot), .s_axi4_awqos(awqos),
    .s_axi4_awregion(awregion), .s_axi4_awvalid(awvalid), .s_axi4_awready(awready),
    .s_axi4_wdata(wdata), .s_axi4_wstrb(wstrb), .s_axi4_wlast(wlast),
    .s_axi4_wvalid(wvalid), .s_axi4_wready(wready),
    .s_axi4_bid(bid), .s_axi4_bresp(bresp), .s_axi4_bvalid(bvalid), .s_axi4_bready(bready),
    .s_axi4_arid(arid), .s_axi4_araddr(araddr), .s_axi4_arlen(arlen),
    .s_axi4_arsize(arsize), .s_axi4_arburst(arburst), .s_axi4_arlock(arlock),
    .s_axi4_arcache(arcache), .s_axi4_arprot(arprot), .s_axi4_arqos(arqos),
    .s_axi4_arregion(arregion), .s_axi4_arvalid(arvalid), .s_axi4_arready(arready),
    .s_axi4_rid(rid), .s_axi4_rdata(rdata), .s_axi4_rresp(rresp),
    .s_axi4_rlast(rlast), .s_axi4_rvalid(rvalid), .s_axi4_rready(rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: one 32-byte word per index, index = byte address / 32 mod 256
  logic [255:0] m_mem [256];
  logic [255:0] wd [256];
  logic [31:0]  ws [256];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout waiting on DUT", name);
  endtask

  function automatic logic [511:0] outs();
    return 512'({awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid});
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_write(inout logic [7:0] idx, input logic [1:0] burst,
                             input logic [255:0] d, input logic [31:0] s);
    if (!burst[1])
      for (int b = 0; b < 32; b++) if (s[b]) m_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    if (burst == INCR) idx = idx + 8'd1;
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input int badlast, input int bdelay, input logic [1:0] exp_resp,
                          input string tag);
    int n, stall;
    logic [3:0] id;
    logic [7:0] idx;
    id  = 4'($urandom);
    idx = 8'(addr >> 5);
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len); awburst = burst;
    awsize = 3'($urandom); awcache = 4'($urandom); awprot = 3'($urandom);
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin awvalid = 1'b0; timed_out({tag, "_aw"}); return; end
    @(negedge clk);
    awvalid = 1'b0;
    stall = 0;
    for (int k = 0; k <= len; k++) begin
      wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k];
      wlast = (badlast >= 0) ? (k == badlast) : (k == len);
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; stall++; end
      if (!wready) begin wvalid = 1'b0; timed_out({tag, "_w"}); return; end
      model_write(idx, burst, wd[k], ws[k]);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk({tag, "_w_stall"}, stall, 0);
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin timed_out({tag, "_b"}); return; end
    repeat (bdelay) @(negedge clk);
    chk({tag, "_b_resp"}, {bvalid, bid, bresp, wready}, {1'b1, id, exp_resp, 1'b0});
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({tag, "_b_drop"}, bvalid, 1'b0);
  endtask

  // rmode: 0 = rready held high, 1 = toggling 1-0-1..., 2 = random
  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input int rmode, input logic [1:0] exp_resp, input string tag);
    logic [255:0] exp_d [256];
    logic [255:0] held;
    logic [7:0]   idx;
    logic [3:0]   id;
    logic         stalled, rr;
    int n, beat, cyc;
    idx = 8'(addr >> 5);
    for (int k = 0; k <= len; k++) begin
      exp_d[k] = burst[1] ? 256'h0 : m_mem[idx];
      if (burst == INCR) idx = idx + 8'd1;
    end
    id = 4'($urandom);
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arburst = burst;
    arsize = 3'($urandom); arqos = 4'($urandom);
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin arvalid = 1'b0; timed_out({tag, "_ar"}); return; end
    @(negedge clk);
    arvalid = 1'b0;
    chk({tag, "_lat1"}, rvalid, 1'b0);
    @(negedge clk);
    chk({tag, "_lat2"}, rvalid, 1'b1);
    beat = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (beat <= len && cyc < 400) begin
      if (rvalid) begin
        if (stalled) chk({tag, "_hold"}, {rdata, rlast, rresp}, {held, beat == len, exp_resp});
        case (rmode)
          0:       rr = 1'b1;
          1:       rr = (cyc % 2 == 0);
          default: rr = 1'($urandom_range(0, 1));
        endcase
        rready = rr;
        if (rr) begin
          chk({tag, "_beat"}, {rid, rresp, rlast, rdata},
              {id, exp_resp, beat == len, exp_d[beat]});
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = rdata;
        end
      end else begin
        rready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    if (beat <= len) begin timed_out({tag, "_r"}); return; end
    chk({tag, "_extra"}, rvalid, 1'b0);
  endtask

  task automatic fill_wd(input int dmode, input int len);
    for (int k = 0; k <= len; k++) begin
      case (dmode)
        1:       begin wd[k] = 256'(k + 1); ws[k] = (k == 2) ? 32'h0000000F : '1; end
        2:       begin wd[k] = {32{8'hA5}};  ws[k] = '1; end
        3:       begin wd[k] = '0;           ws[k] = '1; end
        4:       begin wd[k] = rnd256();     ws[k] = $urandom_range(0, 1) ? '1 : $urandom; end
        default: begin wd[k] = rnd256();     ws[k] = '1; end
      endcase
    end
  endtask

  typedef struct {
    bit         wr;
    logic [31:0] addr;
    int         len;
    logic [1:0] burst;
    int         badlast;
    int         dmode;
    int         rmode;
    logic [1:0] resp;
    string      tag;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = '0;

    tbl[0]  = '{1'b1, 32'h0000_0000, 255, INCR, -1, 3, 0, 2'b00, "zero_fill"};
    tbl[1]  = '{1'b1, 32'h0000_0040, 0,   INCR, -1, 2, 0, 2'b00, "t1_wr"};
    tbl[2]  = '{1'b0, 32'h0000_0040, 0,   INCR, -1, 0, 0, 2'b00, "t1_rd"};
    tbl[3]  = '{1'b1, 32'h0000_0000, 3,   INCR, -1, 1, 0, 2'b00, "t2_wr"};
    tbl[4]  = '{1'b0, 32'h0000_0000, 3,   INCR, -1, 0, 0, 2'b00, "t2_rd"};
    tbl[5]  = '{1'b1, 32'h0000_1FE0, 1,   INCR, -1, 0, 0, 2'b00, "t3_wr"};
    tbl[6]  = '{1'b0, 32'h0000_1FE0, 1,   INCR, -1, 0, 1, 2'b00, "t3_rd"};
    tbl[7]  = '{1'b1, 32'h0000_0100, 2,   INCR,  1, 0, 0, 2'b10, "t4_wlast"};
    tbl[8]  = '{1'b0, 32'h0000_0100, 2,   INCR, -1, 0, 2, 2'b00, "t4_rdback"};
    tbl[9]  = '{1'b0, 32'h0000_0200, 1,   WRAP, -1, 0, 0, 2'b10, "t4_rdwrap"};
    tbl[10] = '{1'b1, 32'h0000_0300, 1,   RESV, -1, 0, 0, 2'b10, "wr_resv"};
    tbl[11] = '{1'b0, 32'h0000_0300, 1,   INCR, -1, 0, 0, 2'b00, "rd_resv"};
    tbl[12] = '{1'b1, 32'hFFFF_E0A3, 0,   FIXED, -1, 0, 0, 2'b00, "wr_hiaddr"};
    tbl[13] = '{1'b0, 32'h0000_00A0, 0,   INCR, -1, 0, 2, 2'b00, "rd_hiaddr"};

    // reset state
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_outs", outs(), '0);
    rst = 1'b0;
    #1 chk("reset_rel_ready", {awready, arready}, 2'b00);
    @(negedge clk);
    chk("reset_ready_up", {awready, arready, wready, bvalid, rvalid}, 5'b11000);

    // directed table
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) begin
        fill_wd(tbl[i].dmode, tbl[i].len);
        do_write(tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].badlast, 0, tbl[i].resp, tbl[i].tag);
      end else begin
        do_read(tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].rmode, tbl[i].resp, tbl[i].tag);
      end
    end

    // FIXED write concurrent with an independent INCR read
    for (int k = 0; k < 4; k++) begin wd[k] = 256'(k + 1); ws[k] = '1; end
    fork
      do_write(32'd5 * 32, 3, FIXED, -1, 0, 2'b00, "t5_wr");
      do_read(32'd9 * 32, 7, INCR, 0, 2'b00, "t5_rd");
    join
    chk("t5_idx5_model", m_mem[5], 256'd4);
    do_read(32'd5 * 32, 1, INCR, 0, 2'b00, "t5_chk");

    // reset in the middle of a write burst
    begin
      logic [7:0] idx;
      logic [255:0] d0, d1;
      idx = 8'd20;
      d0 = rnd256(); d1 = rnd256();
      @(negedge clk);
      awid = 4'h7; awaddr = 32'd20 * 32; awlen = 8'd3; awburst = INCR; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      chk("t6_wready0", wready, 1'b1);
      wvalid = 1'b1; wdata = d0; wstrb = '1; wlast = 1'b0;
      model_write(idx, INCR, d0, '1);
      @(negedge clk);
      chk("t6_wready1", wready, 1'b1);
      wdata = d1;
      model_write(idx, INCR, d1, '1);
      @(negedge clk);
      wvalid = 1'b0;
      rst = 1'b1;
      #1 chk("t6_rst_async", outs(), '0);
      @(negedge clk);
      chk("t6_rst_hold", outs(), '0);
      rst = 1'b0;
      #1 chk("t6_awready_pre", awready, 1'b0);
      @(negedge clk);
      chk("t6_awready_post", {awready, bvalid}, 2'b10);
      bready = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("t6_no_bvalid", bvalid, 1'b0);
      end
      bready = 1'b0;
      do_read(32'd20 * 32, 1, INCR, 0, 2'b00, "t6_rd");
    end

    // randomized bursts against the model
    for (int it = 0; it < 24; it++) begin
      logic [31:0] a;
      logic [1:0]  bu;
      int ln, bl;
      a  = $urandom;
      bu = 2'($urandom_range(0, 3));
      ln = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        bl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ln) : -1;
        fill_wd(4, ln);
        do_write(a, ln, bu, bl, $urandom_range(0, 2),
                 (bu[1] || (bl >= 0 && bl != ln)) ? 2'b10 : 2'b00, "rnd_wr");
      end else begin
        do_read(a, ln, bu, 2, bu[1] ? 2'b10 : 2'b00, "rnd_rd");
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
